// File: rtl/sort4_seq_ctrl.sv
// Sequenced 4-element sorter: one compare-exchange per clock over a 5-step network; result 5 edges after accept, held until out_ready.
// Backpressure: in_ready low from accept until the result is taken; define SORT4_SEQ_DESC_EN for a descending result.
module sort4_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic [WIDTH-1:0] InC,
  input  logic [WIDTH-1:0] InD,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [WIDTH-1:0] OutC,
  output logic [WIDTH-1:0] OutD,
  output logic             busy,
  output logic [2:0]       step
);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] r0, r1, r2, r3;

  // Ties never swap, so equal keys leave the registers untouched.
  function automatic logic needSwap(input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi);
`ifdef SORT4_SEQ_DESC_EN
    return lo < hi;
`else
    return lo > hi;
`endif
  endfunction

  assign OutA = r0;
  assign OutB = r1;
  assign OutC = r2;
  assign OutD = r3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= 3'd0;
      r0        <= '0;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r0       <= InA;
            r1       <= InB;
            r2       <= InC;
            r3       <= InD;
            step     <= 3'd0;
            state    <= SORT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SORT: begin
          case (step)
            3'd0: if (needSwap(r0, r1)) begin r0 <= r1; r1 <= r0; end
            3'd1: if (needSwap(r2, r3)) begin r2 <= r3; r3 <= r2; end
            3'd2: if (needSwap(r0, r2)) begin r0 <= r2; r2 <= r0; end
            3'd3: if (needSwap(r1, r3)) begin r1 <= r3; r3 <= r1; end
            3'd4: if (needSwap(r1, r2)) begin r1 <= r2; r2 <= r1; end
            default: ;
          endcase
          if (step == 3'd4) begin
            step      <= 3'd0;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            step <= step + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          step      <= 3'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Bench for sort4_seq_ctrl: vector table, multi-cycle corner sequences and a randomized back-to-back run against a sorting model.
module tb_sort4_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] InA, InB, InC, InD, OutA, OutB, OutC, OutD;
  logic [2:0] step;

  int checks = 0;
  int errors = 0;

  sort4_seq_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .InA(InA), .InB(InB), .InC(InC), .InD(InD),
    .out_valid(out_valid), .out_ready(out_ready),
    .OutA(OutA), .OutB(OutB), .OutC(OutC), .OutD(OutD),
    .busy(busy), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a, b, c, d;
    logic [15:0] expAsc;
    bit          stable;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] orient(input logic [15:0] asc);
`ifdef SORT4_SEQ_DESC_EN
    return {asc[3:0], asc[7:4], asc[11:8], asc[15:12]};
`else
    return asc;
`endif
  endfunction

  function automatic logic [15:0] refSort(input logic [3:0] a, b, c, d);
    logic [3:0] v[4];
    logic [3:0] t;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return orient({v[0], v[1], v[2], v[3]});
  endfunction

  function automatic logic [15:0] outs();
    return {OutA, OutB, OutC, OutD};
  endfunction

  task automatic waitReady();
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("wait_in_ready", in_ready, 1);
  endtask

  task automatic sortOne(input logic [3:0] a, b, c, d, input logic [15:0] exp,
                         input bit drain, input bit stable);
    waitReady();
    InA = a; InB = b; InC = c; InD = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("accept_in_ready", in_ready, 0);
    for (int s = 0; s < 5; s++) begin
      check("step_walk", step, s);
      check("busy_sort", busy, 1);
      check("sort_out_valid", out_valid, 0);
      if (stable) check("regs_stable", outs(), {a, b, c, d});
      tick();
    end
    check("done_out_valid", out_valid, 1);
    check("done_in_ready", in_ready, 0);
    check("done_busy", busy, 0);
    check("done_step", step, 0);
    check("result", outs(), exp);
    if (drain) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("drain_out_valid", out_valid, 0);
      check("drain_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    logic [15:0] expQ[$];
    logic [15:0] pending;
    int nAcc, nRes, cyc, lastAcc;
    bit accepted;

    vecs[0] = '{a: 4'd9,  b: 4'd3, c: 4'd7,  d: 4'd1, expAsc: 16'h1379, stable: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd0, c: 4'd15, d: 4'd0, expAsc: 16'h00FF, stable: 1'b0};
    vecs[2] = '{a: 4'd5,  b: 4'd5, c: 4'd5,  d: 4'd5, expAsc: 16'h5555, stable: 1'b1};
    vecs[3] = '{a: 4'd1,  b: 4'd2, c: 4'd3,  d: 4'd4, expAsc: 16'h1234, stable: 1'b0};
    vecs[4] = '{a: 4'd0,  b: 4'd14, c: 4'd8, d: 4'd3, expAsc: 16'h038E, stable: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    InA = '0; InB = '0; InC = '0; InD = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_step", step, 0);
    check("rst_outs", outs(), 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      sortOne(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, orient(vecs[i].expAsc), 1'b1, vecs[i].stable);

    // Backpressure: result held while out_ready stays low.
    sortOne(4'd8, 4'd4, 4'd6, 4'd2, orient(16'h2468), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_outs", outs(), orient(16'h2468));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // Inputs changing while sorting must not be sampled.
    InA = 4'd8; InB = 4'd6; InC = 4'd4; InD = 4'd2; in_valid = 1'b1;
    tick();
    InA = 4'd0; InB = 4'd0; InC = 4'd0; InD = 4'd0;
    for (int k = 0; k < 5; k++) begin
      check("drop_in_ready", in_ready, 0);
      tick();
    end
    check("drop_out_valid", out_valid, 1);
    check("drop_result", outs(), orient(16'h2468));
    InA = 4'd3; InB = 4'd1; InC = 4'd2; InD = 4'd0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drop_idle_in_ready", in_ready, 1);
    check("drop_idle_busy", busy, 0);
    tick();
    in_valid = 1'b0;
    check("drop_accept_busy", busy, 1);
    for (int k = 0; k < 5; k++) tick();
    check("drop2_out_valid", out_valid, 1);
    check("drop2_result", outs(), orient(16'h0123));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset during step 2.
    InA = 4'd9; InB = 4'd3; InC = 4'd7; InD = 4'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_step", step, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_step", step, 0);
    check("mid_rst_outs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    sortOne(4'd7, 4'd7, 4'd0, 4'd1, orient(16'h0177), 1'b1, 1'b0);

    // Back-to-back random sets with both handshakes held high.
    nAcc = 0; nRes = 0; cyc = 0; lastAcc = 0;
    out_ready = 1'b1;
    InA = 4'($urandom); InB = 4'($urandom); InC = 4'($urandom); InD = 4'($urandom);
    in_valid = 1'b1;
    while ((nAcc < 10 || nRes < 10) && cyc < 300) begin
      accepted = 1'b0;
      if (out_valid) begin
        pending = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
        check("tp_result", outs(), pending);
        nRes++;
      end
      if (in_ready && in_valid) begin
        expQ.push_back(refSort(InA, InB, InC, InD));
        if (nAcc > 0) check("tp_spacing", cyc - lastAcc, 7);
        lastAcc = cyc;
        nAcc++;
        accepted = 1'b1;
      end
      check("tp_exclusive", int'(in_ready && out_valid), 0);
      tick();
      cyc++;
      if (accepted) begin
        if (nAcc < 10) begin
          InA = 4'($urandom); InB = 4'($urandom); InC = 4'($urandom); InD = 4'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("tp_accepts", nAcc, 10);
    check("tp_results", nRes, 10);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
